// File: rtl/menu_sched_pkg.sv
// Shared constants for the menu controller:
// FSM encodings, key indices and debounce default.
package menu_sched_pkg;

    localparam logic [1:0] ST_MENU = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_EXIT = 2'd2;

    localparam int KEY_NEXT  = 0;
    localparam int KEY_PREV  = 1;
    localparam int KEY_ENTER = 2;
    localparam int KEY_EXIT  = 3;

    localparam int DEB_CYCLES_DEF = 500000;

endpackage

// File: rtl/key_debounce.sv
// One front-panel key: 2-FF sync, stable-count
// debounce and a 1-cycle press pulse.
import menu_sched_pkg::*;

module key_debounce #(
    parameter int DEB_CYCLES = DEB_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic key_n,
    output logic level,
    output logic press
);

    localparam int CW = $clog2(DEB_CYCLES + 1);

    logic          s1;
    logic          s2;
    logic [CW-1:0] cnt;

    // Synchronise the inverted (active-high) key.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
        end else begin
            s1 <= ~key_n;
            s2 <= s1;
        end
    end

    // Accept a new level after DEB_CYCLES differing samples.
    always_ff @(posedge clk) begin
        if (rst) begin
            level <= 1'b0;
            cnt   <= '0;
            press <= 1'b0;
        end else begin
            press <= 1'b0;
            if (s2 == level) begin
                cnt <= '0;
            end else if (cnt == CW'(DEB_CYCLES - 1)) begin
                level <= s2;
                cnt   <= '0;
                press <= s2;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/menu_sched.sv
// Menu FSM, selection register and led/en_sub
// arbitration between the menu and sub-modules.
import menu_sched_pkg::*;

module menu_sched #(
    parameter int N_SUB      = 8,
    parameter int LED_W      = 8,
    parameter int DEB_CYCLES = DEB_CYCLES_DEF,
    localparam int SW        = $clog2(N_SUB)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [6:0]             keys,
    input  logic [N_SUB-1:0]       en_back,
    input  logic [N_SUB*LED_W-1:0] sub_led,
    output logic [N_SUB-1:0]       en_sub,
    output logic [LED_W-1:0]       led,
    output logic [SW-1:0]          cur_sel
);

    localparam logic [SW-1:0]    SEL_MAX = SW'(N_SUB - 1);
    localparam logic [N_SUB-1:0] SUB_ONE = N_SUB'(1);
    localparam logic [LED_W-1:0] LED_ONE = LED_W'(1);

    logic [3:0]       press;
    logic [3:0]       unused_level;
    logic             unused_keys;
    logic [1:0]       state;
    logic [1:0]       state_nxt;
    logic [SW-1:0]    sel_nxt;
    logic [LED_W-1:0] sel_led;
    logic             back_sel;
    logic             go_next;
    logic             go_prev;

    assign unused_keys = ^keys[6:4];

    for (genvar g = 0; g < 4; g++) begin : g_deb
        key_debounce #(
            .DEB_CYCLES(DEB_CYCLES)
        ) u_deb (
            .clk  (clk),
            .rst  (rst),
            .key_n(keys[g]),
            .level(unused_level[g]),
            .press(press[g])
        );
    end

    assign sel_led  = sub_led[int'(cur_sel)*LED_W +: LED_W];
    assign back_sel = en_back[cur_sel];
    assign go_next  = press[KEY_NEXT] & ~press[KEY_PREV];
    assign go_prev  = press[KEY_PREV] & ~press[KEY_NEXT];

    // Next state and selection; cur_sel wraps modulo N_SUB.
    always_comb begin
        state_nxt = state;
        sel_nxt   = cur_sel;
        unique case (state)
            ST_MENU: begin
                if (press[KEY_ENTER]) begin
                    state_nxt = ST_RUN;
                end else if (go_next) begin
                    sel_nxt = (cur_sel == SEL_MAX) ? '0 : cur_sel + 1'b1;
                end else if (go_prev) begin
                    sel_nxt = (cur_sel == '0) ? SEL_MAX : cur_sel - 1'b1;
                end
            end
            ST_RUN: begin
                if (back_sel || press[KEY_EXIT]) begin
                    state_nxt = ST_EXIT;
                end
            end
            ST_EXIT: begin
                if (!back_sel) begin
                    state_nxt = ST_MENU;
                end
            end
            default: state_nxt = ST_MENU;
        endcase
    end

    // State and selection registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_MENU;
            cur_sel <= '0;
        end else begin
            state   <= state_nxt;
            cur_sel <= sel_nxt;
        end
    end

    // Registered outputs: en_sub follows the entered state, led the held one.
    always_ff @(posedge clk) begin
        if (rst) begin
            en_sub <= '0;
            led    <= LED_ONE;
        end else begin
            en_sub <= (state_nxt == ST_RUN) ? (SUB_ONE << sel_nxt) : '0;
            led    <= (state == ST_RUN) ? sel_led : (LED_ONE << cur_sel);
        end
    end

endmodule

// File: tb/tb_menu_sched.sv
// Directed bench for menu_sched with DEB_CYCLES=4,
// N_SUB=8, LED_W=8.
module tb_menu_sched;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [6:0]  keys = 7'h7f;
    logic [7:0]  en_back = '0;
    logic [63:0] sub_led = 64'h1122_3344_55A5_6677;
    logic [7:0]  en_sub;
    logic [7:0]  led;
    logic [2:0]  cur_sel;

    int checks = 0;
    int failures = 0;

    menu_sched #(
        .N_SUB(8),
        .LED_W(8),
        .DEB_CYCLES(4)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .keys   (keys),
        .en_back(en_back),
        .sub_led(sub_led),
        .en_sub (en_sub),
        .led    (led),
        .cur_sel(cur_sel)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic press_key(input int idx);
        keys[idx] = 1'b0;
        tick(12);
        keys[idx] = 1'b1;
        tick(12);
    endtask

    task automatic test_reset;
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        checks++;
        if (en_sub !== 8'h00) begin
            failures++;
            $display("FAIL reset_en_sub: got %h expected 00", en_sub);
        end
        checks++;
        if (led !== 8'h01) begin
            failures++;
            $display("FAIL reset_led: got %h expected 01", led);
        end
        checks++;
        if (cur_sel !== 3'd0) begin
            failures++;
            $display("FAIL reset_sel: got %0d expected 0", cur_sel);
        end
    endtask

    task automatic test_navigation;
        for (int i = 1; i <= 3; i++) begin
            press_key(0);
            checks++;
            if (cur_sel !== 3'(i)) begin
                failures++;
                $display("FAIL next_sel: got %0d expected %0d", cur_sel, i);
            end
        end
        checks++;
        if (led !== 8'h08) begin
            failures++;
            $display("FAIL next_led: got %h expected 08", led);
        end
        for (int i = 0; i < 4; i++) press_key(1);
        checks++;
        if (cur_sel !== 3'd7) begin
            failures++;
            $display("FAIL prev_wrap_sel: got %0d expected 7", cur_sel);
        end
        checks++;
        if (led !== 8'h80) begin
            failures++;
            $display("FAIL prev_wrap_led: got %h expected 80", led);
        end
    endtask

    task automatic test_glitches;
        keys[0] = 1'b0;
        tick(3);
        keys[0] = 1'b1;
        tick(1);
        keys[0] = 1'b0;
        tick(3);
        keys[0] = 1'b1;
        tick(12);
        checks++;
        if (cur_sel !== 3'd7) begin
            failures++;
            $display("FAIL bounce_sel: got %0d expected 7", cur_sel);
        end
        keys[1:0] = 2'b00;
        tick(12);
        keys[1:0] = 2'b11;
        tick(12);
        checks++;
        if (cur_sel !== 3'd7) begin
            failures++;
            $display("FAIL next_prev_sel: got %0d expected 7", cur_sel);
        end
        press_key(3);
        checks++;
        if (cur_sel !== 3'd7 || en_sub !== 8'h00) begin
            failures++;
            $display("FAIL menu_exit_key: got sel=%0d en=%h expected 7/00",
                     cur_sel, en_sub);
        end
    endtask

    task automatic test_enter;
        for (int i = 0; i < 3; i++) press_key(0);
        checks++;
        if (cur_sel !== 3'd2) begin
            failures++;
            $display("FAIL wrap_to_2: got %0d expected 2", cur_sel);
        end
        keys[2] = 1'b0;
        tick(6);
        checks++;
        if (en_sub !== 8'h00) begin
            failures++;
            $display("FAIL enter_early: got %h expected 00", en_sub);
        end
        tick(1);
        checks++;
        if (en_sub !== 8'h04 || led !== 8'h04) begin
            failures++;
            $display("FAIL enter_en_sub: got en=%h led=%h expected 04/04",
                     en_sub, led);
        end
        tick(1);
        checks++;
        if (led !== 8'hA5) begin
            failures++;
            $display("FAIL run_led: got %h expected a5", led);
        end
        keys[2] = 1'b1;
        tick(12);
        press_key(0);
        press_key(1);
        checks++;
        if (cur_sel !== 3'd2 || en_sub !== 8'h04) begin
            failures++;
            $display("FAIL run_keys: got sel=%0d en=%h expected 2/04",
                     cur_sel, en_sub);
        end
    endtask

    task automatic test_return;
        en_back[5] = 1'b1;
        tick(3);
        checks++;
        if (en_sub !== 8'h04) begin
            failures++;
            $display("FAIL other_back: got %h expected 04", en_sub);
        end
        en_back[5] = 1'b0;
        en_back[2] = 1'b1;
        tick(1);
        checks++;
        if (en_sub !== 8'h00) begin
            failures++;
            $display("FAIL back_en_sub: got %h expected 00", en_sub);
        end
        tick(10);
        checks++;
        if (en_sub !== 8'h00 || led !== 8'h04) begin
            failures++;
            $display("FAIL exit_hold: got en=%h led=%h expected 00/04",
                     en_sub, led);
        end
        press_key(0);
        checks++;
        if (cur_sel !== 3'd2) begin
            failures++;
            $display("FAIL exit_drop_keys: got %0d expected 2", cur_sel);
        end
        en_back[2] = 1'b0;
        tick(3);
        checks++;
        if (led !== 8'h04 || en_sub !== 8'h00) begin
            failures++;
            $display("FAIL back_menu: got led=%h en=%h expected 04/00",
                     led, en_sub);
        end
        press_key(2);
        checks++;
        if (en_sub !== 8'h04 || led !== 8'hA5) begin
            failures++;
            $display("FAIL reenter: got en=%h led=%h expected 04/a5",
                     en_sub, led);
        end
        press_key(3);
        checks++;
        if (en_sub !== 8'h00 || led !== 8'h04) begin
            failures++;
            $display("FAIL force_exit: got en=%h led=%h expected 00/04",
                     en_sub, led);
        end
        press_key(0);
        checks++;
        if (cur_sel !== 3'd3 || led !== 8'h08) begin
            failures++;
            $display("FAIL after_force: got sel=%0d led=%h expected 3/08",
                     cur_sel, led);
        end
    endtask

    task automatic test_reset_in_run;
        press_key(1);
        press_key(2);
        checks++;
        if (en_sub !== 8'h04) begin
            failures++;
            $display("FAIL run_before_rst: got %h expected 04", en_sub);
        end
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        checks++;
        if (en_sub !== 8'h00 || cur_sel !== 3'd0 || led !== 8'h01) begin
            failures++;
            $display("FAIL rst_in_run: got en=%h sel=%0d led=%h expected 00/0/01",
                     en_sub, cur_sel, led);
        end
        tick(3);
        checks++;
        if (en_sub !== 8'h00 || led !== 8'h01) begin
            failures++;
            $display("FAIL post_rst: got en=%h led=%h expected 00/01",
                     en_sub, led);
        end
    endtask

    initial begin
        test_reset;
        test_navigation;
        test_glitches;
        test_enter;
        test_return;
        test_reset_in_run;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
